// File: rtl/mem_arbiter.sv
// Shares the single-port data memory between the CPU and a DMA/debug burst requester.
// The CPU has fixed priority; an anti-starvation counter forces DMA beats through.
//
// state | meaning
// IDLE  | no burst; dma_req accepted and latched here
// BURST | beats pending; per-cycle CPU/DMA arbitration
// DONE  | one-cycle completion pulse; CPU always wins
module mem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 16,
  parameter int LEN_W        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        cpu_mem_cmd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_gnt,
  output logic              dma_beat,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_done,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat_idx;
  logic              we;
  logic [SC_W-1:0]   starve_cnt;

  logic cpu_req;
  logic dma_win;

  assign cpu_req = (cpu_mem_cmd == 2'b10) || (cpu_mem_cmd == 2'b01);
  // In BURST a beat is always pending, so the DMA takes every slot the CPU does not.
  assign dma_win = (state == BURST) && !(cpu_req && (int'(starve_cnt) < STARVE_LIMIT));

  assign dma_gnt   = (state == IDLE) && dma_req;
  assign cpu_rdata = mem_rdata;
  assign dma_rdata = mem_rdata;

  always_comb begin
    mem_cmd   = cpu_req ? cpu_mem_cmd : 2'b00;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    cpu_stall = 1'b0;
    dma_beat  = 1'b0;
    if (dma_win) begin
      mem_cmd   = we ? 2'b01 : 2'b10;
      mem_addr  = base + ADDR_W'(beat_idx);
      mem_wdata = dma_wdata;
      dma_beat  = 1'b1;
      cpu_stall = cpu_req;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      base       <= '0;
      len        <= '0;
      we         <= 1'b0;
      beat_idx   <= '0;
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_done   <= 1'b0;
    end else begin
      dma_rvalid <= dma_win && !we;
      dma_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (dma_req) begin
            base       <= dma_addr;
            len        <= dma_len;
            we         <= dma_we;
            beat_idx   <= '0;
            starve_cnt <= '0;
            if (dma_len == '0) begin
              state    <= DONE;
              dma_done <= 1'b1;
            end else begin
              state <= BURST;
            end
          end
        end
        BURST: begin
          if (dma_win) begin
            beat_idx   <= beat_idx + 1'b1;
            starve_cnt <= '0;
            if (beat_idx == len - 1'b1) begin
              state    <= DONE;
              dma_done <= 1'b1;
            end
          end else begin
            starve_cnt <= starve_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a queue-based burst model.
module tb_mem_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cpu_mem_cmd;
  logic [8:0]  cpu_addr;
  logic [15:0] cpu_wdata;
  logic [15:0] cpu_rdata;
  logic        cpu_stall;
  logic        dma_req;
  logic        dma_we;
  logic [8:0]  dma_addr;
  logic [3:0]  dma_len;
  logic        dma_gnt;
  logic        dma_beat;
  logic [15:0] dma_wdata;
  logic        dma_rvalid;
  logic [15:0] dma_rdata;
  logic        dma_done;
  logic [1:0]  mem_cmd;
  logic [8:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(.ADDR_W(9), .DATA_W(16), .LEN_W(4), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_cmd(cpu_mem_cmd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_len(dma_len),
    .dma_gnt(dma_gnt), .dma_beat(dma_beat), .dma_wdata(dma_wdata),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_done(dma_done),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0] cmd;
    logic [8:0] caddr;
    logic       req;
    logic       we;
    logic [8:0] daddr;
    logic [3:0] len;
    logic [1:0] e_cmd;
    logic [8:0] e_addr;
    logic       e_stall;
    logic       e_gnt;
    logic       e_beat;
    logic       e_done;
    logic       e_rv;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic [1:0] cmd, logic [8:0] caddr, logic req, logic we,
                              logic [8:0] daddr, logic [3:0] len, logic [1:0] e_cmd,
                              logic [8:0] e_addr, logic e_stall, logic e_gnt,
                              logic e_beat, logic e_done, logic e_rv);
    vec_t v;
    v.cmd = cmd; v.caddr = caddr; v.req = req; v.we = we; v.daddr = daddr; v.len = len;
    v.e_cmd = e_cmd; v.e_addr = e_addr; v.e_stall = e_stall; v.e_gnt = e_gnt;
    v.e_beat = e_beat; v.e_done = e_done; v.e_rv = e_rv;
    return v;
  endfunction

  // Reference model: a burst is a queue of beat addresses plus a count of CPU wins.
  bit         m_busy;
  bit         m_done_now;
  bit         m_rv_prev;
  bit         m_we;
  int         m_wins;
  logic [8:0] m_q[$];

  logic [1:0]  e_cmd;
  logic [8:0]  e_addr;
  logic [15:0] e_wd;
  logic        e_gnt, e_beat, e_stall, e_done, e_rv;

  initial begin
    bit cpu_req;
    bit nxt_done, nxt_rv;
    logic [8:0] a;

    tbl[0]  = mk(2'b10, 9'h005, 0, 0, 9'h000, 4'd0, 2'b10, 9'h005, 0, 0, 0, 0, 0);
    tbl[1]  = mk(2'b00, 9'h000, 1, 0, 9'h010, 4'd3, 2'b00, 9'h000, 0, 1, 0, 0, 0);
    tbl[2]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h010, 0, 0, 1, 0, 0);
    tbl[3]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h011, 0, 0, 1, 0, 1);
    tbl[4]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h012, 0, 0, 1, 0, 1);
    tbl[5]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b00, 9'h000, 0, 0, 0, 1, 1);
    tbl[6]  = mk(2'b00, 9'h000, 1, 0, 9'h1FE, 4'd4, 2'b00, 9'h000, 0, 1, 0, 0, 0);
    tbl[7]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h1FE, 0, 0, 1, 0, 0);
    tbl[8]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h1FF, 0, 0, 1, 0, 1);
    tbl[9]  = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h000, 0, 0, 1, 0, 1);
    tbl[10] = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b10, 9'h001, 0, 0, 1, 0, 1);
    tbl[11] = mk(2'b00, 9'h000, 0, 0, 9'h000, 4'd0, 2'b00, 9'h000, 0, 0, 0, 1, 1);
    tbl[12] = mk(2'b01, 9'h033, 1, 1, 9'h000, 4'd0, 2'b01, 9'h033, 0, 1, 0, 0, 0);
    tbl[13] = mk(2'b10, 9'h044, 1, 0, 9'h020, 4'd5, 2'b10, 9'h044, 0, 0, 0, 1, 0);
    tbl[14] = mk(2'b11, 9'h007, 0, 0, 9'h000, 4'd0, 2'b00, 9'h007, 0, 0, 0, 0, 0);

    reset = 1'b0;
    cpu_mem_cmd = 2'b10; cpu_addr = 9'h005; cpu_wdata = 16'h1234;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_len = '0;
    dma_wdata = 16'hA5A5; mem_rdata = 16'h0;
    #3;
    chk("rst_mem_cmd", 32'(mem_cmd), 32'(2'b10));
    chk("rst_mem_addr", 32'(mem_addr), 32'h5);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_dma_outs", 32'({dma_gnt, dma_beat, dma_rvalid, dma_done}), 0);
    next_cycle();
    reset = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cpu_mem_cmd = tbl[i].cmd; cpu_addr = tbl[i].caddr;
      dma_req = tbl[i].req; dma_we = tbl[i].we; dma_addr = tbl[i].daddr; dma_len = tbl[i].len;
      #4;
      chk($sformatf("tbl%0d_mem_cmd", i), 32'(mem_cmd), 32'(tbl[i].e_cmd));
      chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d_ctl", i),
          32'({cpu_stall, dma_gnt, dma_beat, dma_done, dma_rvalid}),
          32'({tbl[i].e_stall, tbl[i].e_gnt, tbl[i].e_beat, tbl[i].e_done, tbl[i].e_rv}));
      next_cycle();
    end

    // CPU reads every cycle while a 2-beat DMA write is pending.
    dma_wdata = 16'hBEEF;
    for (int c = 0; c < 10; c++) begin
      bit is_beat;
      cpu_mem_cmd = 2'b10; cpu_addr = 9'(9'h080 + c); cpu_wdata = 16'h0C0C;
      dma_req = (c == 0); dma_we = 1'b1; dma_addr = 9'h040; dma_len = 4'd2;
      is_beat = (c == 4) || (c == 8);
      #4;
      chk($sformatf("cont%0d_mem_cmd", c), 32'(mem_cmd), is_beat ? 32'h1 : 32'h2);
      chk($sformatf("cont%0d_mem_addr", c), 32'(mem_addr),
          is_beat ? ((c == 4) ? 32'h40 : 32'h41) : 32'(9'h080 + c));
      chk($sformatf("cont%0d_mem_wdata", c), 32'(mem_wdata), is_beat ? 32'hBEEF : 32'h0C0C);
      chk($sformatf("cont%0d_ctl", c), 32'({cpu_stall, dma_gnt, dma_beat, dma_done, dma_rvalid}),
          32'({is_beat, c == 0, is_beat, c == 9, 1'b0}));
      next_cycle();
    end

    // Reset in the middle of a 5-beat read burst.
    cpu_mem_cmd = 2'b00; dma_req = 1'b1; dma_we = 1'b0; dma_addr = 9'h100; dma_len = 4'd5;
    #4;
    chk("mid_gnt", 32'(dma_gnt), 1);
    next_cycle();
    dma_req = 1'b0;
    #4;
    chk("mid_beat0", 32'({dma_beat, mem_addr}), 32'({1'b1, 9'h100}));
    next_cycle();
    cpu_mem_cmd = 2'b10; cpu_addr = 9'h009;
    #1;
    reset = 1'b0;
    #2;
    chk("mid_rst_ctl", 32'({cpu_stall, dma_beat, dma_rvalid, dma_done}), 0);
    chk("mid_rst_mem", 32'({mem_cmd, mem_addr}), 32'({2'b10, 9'h009}));
    next_cycle();
    reset = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #4;
      chk($sformatf("post_rst%0d", c), 32'({dma_beat, dma_done, cpu_stall}), 0);
      next_cycle();
    end
    dma_req = 1'b1; dma_len = 4'd1;
    #4;
    chk("post_rst_gnt", 32'(dma_gnt), 1);
    next_cycle();

    // Randomized traffic against the model.
    reset = 1'b0;
    dma_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    m_busy = 0; m_done_now = 0; m_rv_prev = 0; m_wins = 0; m_we = 0; m_q.delete();
    for (int n = 0; n < 2000; n++) begin
      cpu_mem_cmd = 2'($urandom_range(0, 3));
      cpu_addr    = 9'($urandom);
      cpu_wdata   = 16'($urandom);
      dma_req     = ($urandom_range(0, 3) == 0);
      dma_we      = 1'($urandom);
      dma_addr    = 9'($urandom);
      dma_len     = 4'($urandom);
      dma_wdata   = 16'($urandom);
      mem_rdata   = 16'($urandom);
      #4;
      cpu_req = (cpu_mem_cmd == 2'b10) || (cpu_mem_cmd == 2'b01);
      e_gnt = 0; e_beat = 0; e_stall = 0; e_done = m_done_now; e_rv = m_rv_prev;
      e_cmd = cpu_req ? cpu_mem_cmd : 2'b00; e_addr = cpu_addr; e_wd = cpu_wdata;
      nxt_done = 0; nxt_rv = 0;
      if (m_done_now) begin
        // completion cycle: CPU passes through, no request considered
      end else if (!m_busy) begin
        if (dma_req) begin
          e_gnt = 1;
          m_q.delete();
          for (int i = 0; i < int'(dma_len); i++) begin
            a = dma_addr + 9'(i);
            m_q.push_back(a);
          end
          m_we = dma_we; m_wins = 0;
          if (dma_len == 0) nxt_done = 1;
          else m_busy = 1;
        end
      end else if (cpu_req && m_wins < LIMIT) begin
        m_wins++;
      end else begin
        e_beat = 1; e_stall = cpu_req;
        e_cmd = m_we ? 2'b01 : 2'b10;
        e_addr = m_q.pop_front();
        e_wd = dma_wdata;
        m_wins = 0;
        nxt_rv = !m_we;
        if (m_q.size() == 0) begin
          m_busy = 0;
          nxt_done = 1;
        end
      end
      chk("rnd_mem_cmd", 32'(mem_cmd), 32'(e_cmd));
      chk("rnd_mem_addr", 32'(mem_addr), 32'(e_addr));
      chk("rnd_mem_wdata", 32'(mem_wdata), 32'(e_wd));
      chk("rnd_ctl", 32'({cpu_stall, dma_gnt, dma_beat, dma_done, dma_rvalid}),
          32'({e_stall, e_gnt, e_beat, e_done, e_rv}));
      chk("rnd_rdata", 32'({cpu_rdata, dma_rdata}), 32'({mem_rdata, mem_rdata}));
      m_done_now = nxt_done;
      m_rv_prev  = nxt_rv;
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
